// File: rtl/gcd_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gcd_ctrl
//   Control FSM for a subtract-based GCD datapath. It loads both operands, then
//   issues one subtraction per cycle, steered by the datapath compare flags,
//   until a == b. It then presents the result. A go/busy/done/err handshake
//   wraps each job. Zero operands and runaway jobs (more than MAX_ITER
//   subtractions) end in the error state.
//
// Parameters
//   MAX_ITER  subtractions allowed before abort (>= 1)
//   CNT_W     width of iter_cnt; must be able to hold MAX_ITER
//
// Ports
//   clk       clock; all state updates on the rising edge
//   rst       synchronous, active-high reset
//   go        level request; sampled in IDLE; held until done/err is seen
//   a_eq_b    datapath flag: a_reg == b_reg
//   a_lt_b    datapath flag: a_reg <  b_reg
//   a_zero    datapath flag: a_reg == 0
//   b_zero    datapath flag: b_reg == 0
//   ldA, ldB  load both operand registers (always driven together)
//   sel       subtract select: 0 = b -= a, 1 = a -= b
//   out       result select: 1 = drive GCD from a_reg
//   strt      datapath enable; 0 = registers hold
//   busy      high in LOAD and CALC
//   done      high in DONE; GCD is valid while high
//   err       high in ERR (zero operand or timeout)
//   iter_cnt  subtractions issued in the current or last job
// -----------------------------------------------------------------------------
module gcd_ctrl #(
    parameter int unsigned MAX_ITER = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    input  logic             a_zero,
    input  logic             b_zero,
    output logic             ldA,
    output logic             ldB,
    output logic             sel,
    output logic             out,
    output logic             strt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Raw FSM outputs, before the reset gate below.
    logic ld_raw, sel_raw, out_raw, strt_raw, busy_raw, done_raw, err_raw;

    // NOTE: reset is sampled on the clock edge here, so it sits inside the
    // clocked branch instead of the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // forgets to assign one would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_raw   = 1'b0;
        sel_raw  = 1'b0;
        out_raw  = 1'b0;
        strt_raw = 1'b0;
        busy_raw = 1'b0;
        done_raw = 1'b0;
        err_raw  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end

            S_LOAD: begin
                ld_raw   = 1'b1;
                busy_raw = 1'b1;
                state_d  = S_CALC;
            end

            // Mealy: this cycle's flags decide this cycle's command. The
            // iteration limit is tested before a subtraction can be issued,
            // so the counter stops at MAX_ITER and never wraps.
            S_CALC: begin
                busy_raw = 1'b1;
                if (a_zero || b_zero) begin
                    state_d = S_ERR;
                end else if (a_eq_b) begin
                    strt_raw = 1'b1;
                    out_raw  = 1'b1;
                    state_d  = S_DONE;
                end else if (cnt_q == MAX_CNT) begin
                    state_d = S_ERR;
                end else if (a_lt_b) begin
                    strt_raw = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    strt_raw = 1'b1;
                    sel_raw  = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                done_raw = 1'b1;
                strt_raw = 1'b1;
                out_raw  = 1'b1;
                if (!go) state_d = S_IDLE;
            end

            S_ERR: begin
                err_raw = 1'b1;
                if (!go) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // The state register only clears at the edge that ends the reset cycle.
    // Gating the outputs with rst keeps the datapath from loading or
    // subtracting during that cycle.
    always_comb begin
        ldA  = ld_raw   & ~rst;
        ldB  = ld_raw   & ~rst;
        sel  = sel_raw  & ~rst;
        out  = out_raw  & ~rst;
        strt = strt_raw & ~rst;
        busy = busy_raw & ~rst;
        done = done_raw & ~rst;
        err  = err_raw  & ~rst;
    end

    assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
`timescale 1ns/1ps
module tb_gcd_ctrl;

    typedef struct {
        int k;       // which instance ran the job
        bit is_err;
        int gcd;
        int n;       // expected final iter_cnt
        int lat;     // cycles from go-seen to done/err
        int t0;
    } exp_t;

    localparam int MAXV [2] = '{16, 4};

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic       go_s   [2];
    logic [3:0] opa    [2];
    logic [3:0] opb    [2];
    logic [3:0] a_r    [2];
    logic [3:0] b_r    [2];
    logic       eq_f   [2];
    logic       lt_f   [2];
    logic       az_f   [2];
    logic       bz_f   [2];
    logic       ldA_s  [2];
    logic       ldB_s  [2];
    logic       sel_s  [2];
    logic       out_s  [2];
    logic       strt_s [2];
    logic       busy_s [2];
    logic       done_s [2];
    logic       err_s  [2];
    logic [4:0] iter_s [2];

    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_ctrl #(.MAX_ITER(16), .CNT_W(5)) dut16 (
        .clk(clk), .rst(rst), .go(go_s[0]),
        .a_eq_b(eq_f[0]), .a_lt_b(lt_f[0]), .a_zero(az_f[0]), .b_zero(bz_f[0]),
        .ldA(ldA_s[0]), .ldB(ldB_s[0]), .sel(sel_s[0]), .out(out_s[0]),
        .strt(strt_s[0]), .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]),
        .iter_cnt(iter_s[0])
    );

    gcd_ctrl #(.MAX_ITER(4), .CNT_W(5)) dut4 (
        .clk(clk), .rst(rst), .go(go_s[1]),
        .a_eq_b(eq_f[1]), .a_lt_b(lt_f[1]), .a_zero(az_f[1]), .b_zero(bz_f[1]),
        .ldA(ldA_s[1]), .ldB(ldB_s[1]), .sel(sel_s[1]), .out(out_s[1]),
        .strt(strt_s[1]), .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]),
        .iter_cnt(iter_s[1])
    );

    // Datapath environment: operand registers and compare flags.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ldA_s[k] && ldB_s[k]) begin
                a_r[k] <= opa[k];
                b_r[k] <= opb[k];
            end else if (strt_s[k] && !out_s[k]) begin
                if (sel_s[k]) a_r[k] <= a_r[k] - b_r[k];
                else          b_r[k] <= b_r[k] - a_r[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            eq_f[k] = (a_r[k] == b_r[k]);
            lt_f[k] = (a_r[k] <  b_r[k]);
            az_f[k] = (a_r[k] == 4'd0);
            bz_f[k] = (b_r[k] == 4'd0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: GCD by Euclid; subtraction count of the subtract-only
    // algorithm equals the sum of Euclid quotients minus one.
    function automatic exp_t model(input int k, input int a, input int b, input int t0);
        exp_t e;
        int x, y, q, r, nsub;
        e.k = k; e.t0 = t0; e.gcd = 0;
        if (a == 0 || b == 0) begin
            e.is_err = 1'b1; e.n = 0; e.lat = 3;
        end else begin
            x = a; y = b; nsub = 0;
            while (y != 0) begin
                q = x / y; r = x % y;
                nsub += q;
                x = y; y = r;
            end
            nsub -= 1;
            e.gcd = x;
            if (nsub > MAXV[k]) begin
                e.is_err = 1'b1; e.n = MAXV[k]; e.lat = 3 + MAXV[k];
            end else begin
                e.is_err = 1'b0; e.n = nsub; e.lat = 3 + nsub;
            end
        end
        return e;
    endfunction

    // Monitor: protocol invariants every cycle, scoreboard on each job end.
    logic prev_end [2] = '{1'b0, 1'b0};
    int   subs     [2] = '{0, 0};

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            check("ld_pair", int'(ldA_s[k]), int'(ldB_s[k]));
            check("ld_vs_strt", int'(ldA_s[k] & strt_s[k]), 0);
            if (!strt_s[k] && !done_s[k])
                check("sel_out_idle", int'({sel_s[k], out_s[k]}), 0);
            if (err_s[k]) check("strt_in_err", int'(strt_s[k]), 0);
            check("onehot_status", int'(busy_s[k]) + int'(done_s[k]) + int'(err_s[k]) > 1 ? 1 : 0, 0);

            if (ldA_s[k]) subs[k] = 0;
            else if (strt_s[k] && !out_s[k]) subs[k]++;

            if ((done_s[k] || err_s[k]) && !prev_end[k]) begin
                if (sb.size() == 0) begin
                    check("unexpected_end", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("end_inst", k, e.k);
                    check("err", int'(err_s[k]), int'(e.is_err));
                    check("done", int'(done_s[k]), int'(!e.is_err));
                    check("latency", cyc - e.t0, e.lat);
                    check("iter_cnt", int'(iter_s[k]), e.n);
                    check("subs_issued", subs[k], e.n);
                    if (!e.is_err) begin
                        check("out_sel", int'(out_s[k]), 1);
                        check("gcd", int'(a_r[k]), e.gcd);
                    end
                end
            end
            prev_end[k] = done_s[k] || err_s[k];
        end
    end

    task automatic run_job(input int k, input int a, input int b, input bit drop_early);
        exp_t e;
        bit   seen;
        @(negedge clk);
        opa[k] = 4'(a); opb[k] = 4'(b);
        go_s[k] = 1'b1;
        e = model(k, a, b, cyc);
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (drop_early && i == 0) go_s[k] = 1'b0;
            if (done_s[k] || err_s[k]) begin seen = 1'b1; break; end
        end
        if (!seen) check("job_end_timeout", 0, 1);
        if (!drop_early) begin
            repeat ($urandom_range(2, 0)) begin
                @(negedge clk);
                check("end_held", int'(done_s[k] | err_s[k]), 1);
            end
            go_s[k] = 1'b0;
        end
        @(negedge clk);
        check("back_idle", int'({busy_s[k], done_s[k], err_s[k], strt_s[k]}), 0);
        check("iter_hold_idle", int'(iter_s[k]), e.n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt3;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            go_s[k] = 1'b0; opa[k] = '0; opb[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check("reset_outputs", int'({ldA_s[k], ldB_s[k], sel_s[k], out_s[k], strt_s[k],
                                         busy_s[k], done_s[k], err_s[k], iter_s[k]}), 0);
        rst = 1'b0;

        // Directed cases.
        run_job(0, 12, 8, 1'b0);
        run_job(0, 7, 7, 1'b0);
        run_job(0, 15, 1, 1'b0);
        run_job(0, 0, 5, 1'b0);
        run_job(0, 0, 0, 1'b0);
        run_job(0, 3, 0, 1'b0);
        run_job(1, 15, 1, 1'b0);  // timeout after 4 subtractions
        run_job(1, 5, 1, 1'b0);   // exactly MAX_ITER subtractions, still done
        run_job(0, 12, 8, 1'b1);  // go dropped during LOAD does not abort

        // Reset during the third subtraction of a 15,1 job.
        @(negedge clk);
        opa[0] = 4'd15; opb[0] = 4'd1; go_s[0] = 1'b1;
        cnt3 = 0;
        for (int i = 0; i < 20 && cnt3 < 3; i++) begin
            @(negedge clk);
            if (strt_s[0] && !out_s[0]) cnt3++;
        end
        check("reached_third_sub", cnt3, 3);
        rst = 1'b1; go_s[0] = 1'b0;
        #1;
        check("rst_cycle_no_cmd", int'({ldA_s[0], ldB_s[0], strt_s[0]}), 0);
        @(negedge clk);
        rst = 1'b0;
        check("after_rst_outputs", int'({ldA_s[0], ldB_s[0], sel_s[0], out_s[0], strt_s[0],
                                         busy_s[0], done_s[0], err_s[0], iter_s[0]}), 0);
        run_job(0, 9, 6, 1'b0);

        // Randomized jobs on both instances.
        for (int j = 0; j < 40; j++)
            run_job(int'($urandom_range(1, 0)), int'($urandom_range(15, 0)),
                    int'($urandom_range(15, 0)), bit'($urandom_range(1, 0)));

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
